// File: rtl/xadc_seq_pkg.sv
// rtl/xadc_seq_pkg.sv - shared state encoding and channel constants for the XADC DRP sequencer
//
// Purpose : common definitions imported by rr_next_sel and xadc_drp_sequencer.
// Contents: NUM_CH, sequencer state enum, default DRP channel addresses,
//           reset value of the round-robin pointer.
package xadc_seq_pkg;

    localparam int NUM_CH = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EOC  = 2'd1,
        ISSUE     = 2'd2,
        WAIT_DRDY = 2'd3
    } seq_state_t;

    // Default XADC status register addresses: temperature, VCCINT, VCCAUX, VCCBRAM
    localparam logic [6:0] DEF_CH0_ADDR = 7'h00;
    localparam logic [6:0] DEF_CH1_ADDR = 7'h01;
    localparam logic [6:0] DEF_CH2_ADDR = 7'h02;
    localparam logic [6:0] DEF_CH3_ADDR = 7'h06;

    // Pointer starts on the last channel so the first scan begins at channel 0
    localparam logic [1:0] LAST_CH_RESET = 2'd3;

endpackage

// File: rtl/rr_next_sel.sv
// rtl/rr_next_sel.sv - combinational round-robin picker over the channel enable mask
//
// Purpose : returns the first set bit of mask scanning cyclically from last+1,
//           wrapping around so that last itself is the final candidate.
// Ports   : mask [3:0] in  - channel enable mask
//           last [1:0] in  - previously selected channel
//           sel  [1:0] out - next channel to read (equals last when any=0)
//           any        out - at least one channel enabled
module rr_next_sel
    import xadc_seq_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [1:0]        last,
    output logic [1:0]        sel,
    output logic              any
);

    // Walk candidates from farthest (last itself) to nearest (last+1) so the
    // nearest enabled channel is the one left standing.
    always_comb begin
        sel = last;
        any = 1'b0;
        for (int k = NUM_CH; k >= 1; k--) begin
            if (mask[last + 2'(k)]) begin
                sel = last + 2'(k);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xadc_drp_sequencer.sv
// rtl/xadc_drp_sequencer.sv - XADC DRP read sequencer with round-robin channel sharing
//
// Purpose : waits for end-of-conversion, issues a one-cycle DRP read, captures
//           the returned word and forwards it as a channel-tagged sample.
// Optional: define XADC_SEQ_TIMEOUT_EN to abort reads that never see drdy_in
//           within TIMEOUT_CYCLES and raise a sticky timeout_err.
// Ports   : clk, rst (sync, active high)
//           ch_en[3:0]    in  - channel enable mask
//           eoc_in        in  - end-of-conversion pulse
//           drdy_in       in  - DRP data ready
//           do_in[15:0]   in  - DRP read data
//           den_out       out - DRP enable, one cycle per read
//           dwe_out       out - DRP write enable, always 0
//           daddr_out[6:0] out - DRP address, held until the next read
//           di_out[15:0]  out - DRP write data, always 0
//           sample_out[15:0], sample_ch[1:0], sample_valid out - tagged sample
//           busy          out - read in flight
//           overrun       out - one-cycle pulse, conversion result dropped
//           timeout_err   out - sticky timeout flag (0 without the option)
module xadc_drp_sequencer
    import xadc_seq_pkg::*;
#(
    parameter logic [6:0] CH0_ADDR       = DEF_CH0_ADDR,
    parameter logic [6:0] CH1_ADDR       = DEF_CH1_ADDR,
    parameter logic [6:0] CH2_ADDR       = DEF_CH2_ADDR,
    parameter logic [6:0] CH3_ADDR       = DEF_CH3_ADDR,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ch_en,
    input  logic        eoc_in,
    input  logic        drdy_in,
    input  logic [15:0] do_in,
    output logic        den_out,
    output logic        dwe_out,
    output logic [6:0]  daddr_out,
    output logic [15:0] di_out,
    output logic [15:0] sample_out,
    output logic [1:0]  sample_ch,
    output logic        sample_valid,
    output logic        busy,
    output logic        overrun,
    output logic        timeout_err
);

    seq_state_t  state;
    seq_state_t  state_nx;
    logic [1:0]  last_ch;
    logic [1:0]  sel_q;
    logic [1:0]  rr_sel;
    logic        rr_any;
    logic [6:0]  sel_addr;
    logic        eoc_pending;
    logic        take_eoc;
    logic        drdy_hit;
    logic        tmo_hit;

    rr_next_sel u_rr (
        .mask (ch_en),
        .last (last_ch),
        .sel  (rr_sel),
        .any  (rr_any)
    );

    always_comb begin
        case (rr_sel)
            2'd0:    sel_addr = CH0_ADDR;
            2'd1:    sel_addr = CH1_ADDR;
            2'd2:    sel_addr = CH2_ADDR;
            default: sel_addr = CH3_ADDR;
        endcase
    end

    // A buffered eoc counts the same as a live one once we are back in WAIT_EOC
    assign take_eoc = (state == WAIT_EOC) && rr_any && (eoc_in || eoc_pending);
    assign drdy_hit = (state == WAIT_DRDY) && drdy_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (rr_any) begin
                    state_nx = WAIT_EOC;
                end
            end
            WAIT_EOC: begin
                if (!rr_any) begin
                    state_nx = IDLE;
                end else if (eoc_in || eoc_pending) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                state_nx = WAIT_DRDY;
            end
            WAIT_DRDY: begin
                if (drdy_in || tmo_hit) begin
                    state_nx = WAIT_EOC;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_ch      <= LAST_CH_RESET;
            sel_q        <= 2'd0;
            daddr_out    <= 7'h00;
            sample_out   <= 16'h0000;
            sample_ch    <= 2'd0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            eoc_pending  <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            overrun      <= 1'b0;

            // Single-entry buffer for conversions that land while a read is busy
            if (eoc_in && (state != WAIT_EOC)) begin
                eoc_pending <= 1'b1;
                if (eoc_pending) begin
                    overrun <= 1'b1;
                end
            end else if (take_eoc) begin
                eoc_pending <= 1'b0;
            end

            if (take_eoc) begin
                last_ch   <= rr_sel;
                sel_q     <= rr_sel;
                daddr_out <= sel_addr;
            end

            if (drdy_hit) begin
                sample_out   <= do_in;
                sample_ch    <= sel_q;
                sample_valid <= 1'b1;
            end
        end
    end

`ifdef XADC_SEQ_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       timeout_q;

    // drdy_in on the expiry cycle takes priority, so the abort needs !drdy_in
    assign tmo_hit = (state == WAIT_DRDY) && !drdy_in &&
                     (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt   <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            if (state == WAIT_DRDY) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end else begin
                tmo_cnt <= 8'd0;
            end
            if (tmo_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_q;
`else
    logic [31:0] unused_timeout_cfg;

    assign unused_timeout_cfg = TIMEOUT_CYCLES;
    assign tmo_hit            = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    assign den_out = (state == ISSUE);
    assign busy    = (state == ISSUE) || (state == WAIT_DRDY);
    assign dwe_out = 1'b0;
    assign di_out  = 16'h0000;

endmodule

// File: doc/xadc_drp_sequencer.md
Name: xadc_drp_sequencer

Overview:
- Sequences XADC DRP reads: waits for end-of-conversion, issues a single-cycle DRP read strobe, captures DRP read data, and forwards a tagged sample to the 8-tap averaging/temperature datapath.
- Shares the single DRP read port round-robin among up to 4 XADC status channels (temperature, VCCINT, VCCAUX, VCCBRAM), selected by an enable mask.
- Sits between the XADC primitive and the averaging DSP; the averager consumes a sample only when sample_valid is high.

Parameters:
- CH0_ADDR, 7'h00, DRP address of channel 0 (temperature)
- CH1_ADDR, 7'h01, DRP address of channel 1 (VCCINT)
- CH2_ADDR, 7'h02, DRP address of channel 2 (VCCAUX)
- CH3_ADDR, 7'h06, DRP address of channel 3 (VCCBRAM)
- TIMEOUT_CYCLES, 255, max cycles den_out-to-drdy_in before abort (used only with the optional feature)

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous active-high reset
- ch_en  in  4  channel enable mask; bit i enables CHi_ADDR
- eoc_in  in  1  XADC end-of-conversion pulse
- drdy_in  in  1  XADC DRP data ready
- do_in  in  16  XADC DRP read data
- den_out  out  1  DRP enable, one-cycle pulse
- dwe_out  out  1  DRP write enable, constant 0
- daddr_out  out  7  DRP address
- di_out  out  16  DRP write data, constant 0
- sample_out  out  16  captured raw DRP word
- sample_ch  out  2  channel index of sample_out
- sample_valid  out  1  one-cycle strobe, sample_out/sample_ch valid
- busy  out  1  high in ISSUE and WAIT_DRDY
- overrun  out  1  one-cycle pulse, conversion result dropped
- timeout_err  out  1  sticky DRP timeout flag (optional feature only; otherwise constant 0)

Behaviour:
- Reset values: den_out=0, daddr_out=0, sample_out=0, sample_ch=0, sample_valid=0, busy=0, overrun=0, timeout_err=0, state=IDLE, last_ch=3, eoc_pending=0.
- Reset mid-transaction aborts the read. den_out is low from the first reset edge, and any later drdy_in is ignored.
- States:
  - IDLE: stays while ch_en==0. Otherwise goes to WAIT_EOC next cycle.
  - WAIT_EOC: goes to IDLE if ch_en==0. On eoc_in or eoc_pending, selects the next channel and goes to ISSUE. eoc_pending is cleared.
  - ISSUE: den_out=1 for exactly this one cycle, with daddr_out=CHsel_ADDR. Goes to WAIT_DRDY.
  - WAIT_DRDY: on drdy_in, registers do_in into sample_out and sel into sample_ch, pulses sample_valid next cycle, and goes to WAIT_EOC.
- Channel selection: take the first set bit of ch_en scanning cyclically from last_ch+1. last_ch updates to the selected channel. The first read after reset therefore uses the lowest enabled channel. ch_en is sampled only at selection; mask changes never disturb an in-flight read.
- Latency:
  - eoc_in high at edge t gives den_out high during cycle t+1.
  - drdy_in high at edge u gives sample_valid high during cycle u+1.
- daddr_out holds its value after ISSUE until the next ISSUE.
- eoc_in outside WAIT_EOC sets eoc_pending. If eoc_pending is already 1, it pulses overrun for one cycle, and the pending flag stays 1 (depth 1).
- eoc_in in the same cycle as the WAIT_DRDY→WAIT_EOC transition sets eoc_pending, which is consumed on the next cycle.
- drdy_in outside WAIT_DRDY is ignored.
- Data is passed unmodified (16 bits); scaling stays in the averager.

Optional Feature:
- Macro: XADC_SEQ_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit counter runs in WAIT_DRDY.
  - When the counter reaches TIMEOUT_CYCLES without drdy_in, the block sets timeout_err (sticky until rst), emits no sample_valid, and returns to WAIT_EOC.
  - drdy_in on the same cycle as expiry wins and the sample is delivered.
- Without the macro: no counter, timeout_err tied 0, and WAIT_DRDY waits indefinitely.

Decomposition:
- Package xadc_seq_pkg holds:
  - state encoding constants (IDLE, WAIT_EOC, ISSUE, WAIT_DRDY)
  - default channel address constants
  - NUM_CH=4
- One combinational sub-module, rr_next_sel: inputs mask[3:0] and last[1:0]; outputs sel[1:0] and any.

Test Plan:
- ch_en=4'b0001, eoc_in pulse at cycle 10, drdy_in 3 cycles after den_out with do_in=16'hA5C0 → den_out in cycle 11 with daddr_out=7'h00; sample_valid one cycle with sample_out=16'hA5C0, sample_ch=0.
- ch_en=4'b1011, 6 eoc pulses each with a prompt drdy → sample_ch sequence 0,1,3,0,1,3 and daddr_out 00,01,06,00,01,06.
- Two eoc_in pulses while in WAIT_DRDY → exactly one overrun pulse, on the second eoc; after drdy, one extra read issues without a new eoc.
- rst asserted 1 cycle after den_out, drdy_in arrives 2 cycles later → no sample_valid; all outputs at reset values; next read uses the lowest enabled channel.
- ch_en→0 during WAIT_DRDY → in-flight sample still delivered; state then goes to IDLE; further eoc pulses produce no den_out.
- With XADC_SEQ_TIMEOUT_EN, no drdy for 255 cycles → timeout_err=1 and sticky, no sample_valid; the next eoc issues a read normally.
